fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter PC_W, default 9, meaning the width of the program counter / instruction-memory byte address.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Stall  input  1  hazard hold; when 1, PC and IF/ID register keep their values.
REQ-005 PcSel  input  1  redirect request from the branch unit (1 = branch/jal taken).
REQ-006 BrPC  input  32  redirect target from the branch unit; only bits [PC_W-1:0] used.
REQ-007 Instr_rd  input  32  instruction-memory read data for address Pc_out, valid in the same cycle.
REQ-008 Pc_out  output  PC_W  current fetch address to instruction memory (registered PC).
REQ-009 IfId_PC  output  PC_W  PC of the instruction held in the IF/ID register.
REQ-010 IfId_Instr  output  32  instruction held in the IF/ID register.
REQ-011 IfId_Valid  output  1  1 when IfId_Instr is a real fetched instruction; 0 for a bubble.
REQ-012 Misalign_Err  output  1  sticky flag: a redirect target with BrPC[1:0] != 0 was applied.
REQ-013 Fetch_Count  output  32  number of valid instructions delivered into IF/ID since reset.

Function
REQ-014 State machine SHALL have states RUN and PEND (redirect captured during stall, not yet applied).
REQ-015 RUN, Stall=0, PcSel=0: PC <= PC+4 (mod 2^PC_W, wraps to 0), IF/ID <= {Pc_out, Instr_rd, Valid=1}, Fetch_Count += 1.
REQ-016 RUN, Stall=0, PcSel=1: PC <= {BrPC[PC_W-1:2], 2'b00}; IF/ID <= {Pc_out, NOP 32'h00000013, Valid=0}; Fetch_Count unchanged.
REQ-017 RUN, Stall=1, PcSel=0: PC, IF/ID, Fetch_Count hold.
REQ-018 RUN, Stall=1, PcSel=1: PC and IF/ID hold; target latched into pending register; next state PEND.
REQ-019 PEND, Stall=1: hold everything; a new PcSel=1 overwrites the pending target (latest wins).
REQ-020 PEND, Stall=0: PC <= PcSel ? live BrPC target : pending target; IF/ID loaded with bubble (Valid=0, NOP); next state RUN.
REQ-021 Redirect-to-PC latency SHALL be exactly one cycle when not stalled; the wrong-path instruction at the old PC never appears with Valid=1.
REQ-022 Misalign_Err SHALL set on the edge a target with bits [1:0] != 0 is applied to PC, and clear only on reset.
REQ-023 Fetch_Count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 BrPC bits [31:PC_W] SHALL be ignored without error.

Reset
REQ-025 While reset=1 (asynchronously): PC=0, Pc_out=0, IfId_PC=0, IfId_Instr=32'h00000013, IfId_Valid=0, Misalign_Err=0, Fetch_Count=0, state RUN, pending target cleared.
REQ-026 Reset asserted while in PEND SHALL discard the pending redirect; first post-reset fetch is address 0.
REQ-027 First rising edge after reset release with Stall=0 SHALL load IF/ID with address 0 and Valid=1.

Structure
REQ-028 Shared package SHALL hold: fetch state enum {RUN, PEND}, NOP encoding 32'h00000013, PC increment constant 4.
REQ-029 PC register with priority mux (reset > applied redirect > stall hold > +4) SHALL be a sub-module named fetch_pc_reg; IF/ID register, FSM, counters stay in fetch_stage.

Verification
REQ-030 Reset then 4 cycles Stall=0, Instr_rd=A,B,C,D -> Pc_out 0,4,8,12,16; IfId_Valid=1 each cycle; Fetch_Count=4.
REQ-031 At Pc_out=8, PcSel=1, BrPC=32'h40 -> next cycle Pc_out=0x40, IfId_Valid=0, IfId_Instr=0x13; following cycle IfId_PC=0x40, Valid=1.
REQ-032 Stall=1 with PcSel=1 BrPC=0x20, then PcSel=1 BrPC=0x30 while still stalled, release -> Pc_out=0x30 one cycle after release, one bubble.
REQ-033 PC_W=9, run from 0x1FC with Stall=0 -> Pc_out wraps to 0x000, no error.
REQ-034 Redirect BrPC=32'h00000106 -> Pc_out=0x104, Misalign_Err=1 and stays 1 until reset.
REQ-035 Assert reset asynchronously mid-cycle while in PEND -> all outputs at REQ-025 values before next clock edge; after release fetch restarts at 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, NOP filler, PC step.
// Pure declarations; no latency and no flow control.
package fetch_stage_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return lo_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset > applied redirect (word-aligned) > stall hold > +4.
// One-cycle update; stall holds the value, redirect ignores stall.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_vld,
  input  logic [PC_W-1:0] redir_pc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redir_vld) begin
      pc_d = {redir_pc[PC_W-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_q + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register, redirect FSM (redirects during stall are parked in PEND).
// Redirect reaches PC one cycle after it is applied; Stall holds PC and IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic [31:0]     Instr_rd,
  output logic [PC_W-1:0] Pc_out,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Misalign_Err,
  output logic [31:0]     Fetch_Count
);

  fetch_state_e    state_d, state_q;
  logic [PC_W-1:0] pend_pc_d, pend_pc_q;
  logic [PC_W-1:0] ifid_pc_d, ifid_pc_q;
  logic [31:0]     ifid_instr_d, ifid_instr_q;
  logic            ifid_vld_d, ifid_vld_q;
  logic            misalign_d, misalign_q;
  logic [31:0]     fetch_cnt_d, fetch_cnt_q;

  logic            redir_vld;
  logic [PC_W-1:0] redir_pc;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] pc;

  // Upper target bits fall outside the instruction memory and are dropped.
  assign br_pc = BrPC[PC_W-1:0];
  logic unused_br_hi;
  assign unused_br_hi = ^BrPC[31:PC_W];

  fetch_pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (reset),
    .stall     (Stall),
    .redir_vld (redir_vld),
    .redir_pc  (redir_pc),
    .pc        (pc)
  );

  always_comb begin
    state_d      = state_q;
    pend_pc_d    = pend_pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    misalign_d   = misalign_q;
    fetch_cnt_d  = fetch_cnt_q;
    redir_vld    = 1'b0;
    redir_pc     = br_pc;

    case (state_q)
      RUN: begin
        if (Stall) begin
          if (PcSel) begin
            pend_pc_d = br_pc;
            state_d   = PEND;
          end
        end else if (PcSel) begin
          redir_vld = 1'b1;
        end else begin
          ifid_pc_d    = pc;
          ifid_instr_d = Instr_rd;
          ifid_vld_d   = 1'b1;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end
      end
      PEND: begin
        if (Stall) begin
          if (PcSel) begin
            pend_pc_d = br_pc;
          end
        end else begin
          // A live redirect is younger than the parked one, so it wins.
          redir_vld = 1'b1;
          redir_pc  = PcSel ? br_pc : pend_pc_q;
          pend_pc_d = '0;
          state_d   = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        pend_pc_d = '0;
      end
    endcase

    // The instruction at the old PC is wrong-path: replace it with a bubble.
    if (redir_vld) begin
      ifid_pc_d    = pc;
      ifid_instr_d = NOP_INSTR;
      ifid_vld_d   = 1'b0;
      if (is_misaligned(redir_pc[1:0])) begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pend_pc_q    <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_vld_q   <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_pc_q    <= pend_pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
      misalign_q   <= misalign_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign Pc_out       = pc;
  assign IfId_PC      = ifid_pc_q;
  assign IfId_Instr   = ifid_instr_q;
  assign IfId_Valid   = ifid_vld_q;
  assign Misalign_Err = misalign_q;
  assign Fetch_Count  = fetch_cnt_q;

endmodule
